mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 49 ++++
 rtl/mem_ram.sv | 25 ++
 rtl/mem_responder.sv | 174 +++++++++++++++++
 tb/tb_mem_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: command and state encodings,
// memory-mapped I/O addresses and the address decoder.
package mem_responder_pkg;

    // CPU memory command encoding; 2'b11 is never a legal command.
    typedef enum logic [1:0] {
        MNONE    = 2'b00,
        MREAD    = 2'b01,
        MWRITE   = 2'b10,
        MILLEGAL = 2'b11
    } mem_cmd_e;

    // Access sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Memory-mapped peripherals.
    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;

    // Address regions seen by the responder.
    typedef enum logic [1:0] {
        RGN_RAM  = 2'd0,
        RGN_LED  = 2'd1,
        RGN_SW   = 2'd2,
        RGN_NONE = 2'd3
    } region_e;

    // Classify a zero-extended word address. Peripheral addresses take
    // priority so that a RAM larger than 256 words cannot shadow them.
    function automatic region_e decode_addr(input logic [31:0] addr,
                                            input logic [31:0] ram_words);
        region_e rgn;
        if (addr == {23'd0, LED_ADDR}) begin
            rgn = RGN_LED;
        end else if (addr == {23'd0, SW_ADDR}) begin
            rgn = RGN_SW;
        end else if (addr < ram_words) begin
            rgn = RGN_RAM;
        end else begin
            rgn = RGN_NONE;
        end
        return rgn;
    endfunction

endpackage

// File: rtl/mem_ram.sv
// Single-port RAM: synchronous write, combinational read of the addressed
// word. Contents are deliberately not reset so data survives a CPU reset.
module mem_ram #(
    parameter int unsigned WORDS = 256,
    parameter int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [15:0]   wdata_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [WORDS];

    // Store the write word on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory responder for a simple CPU: captures one read/write command, waits a
// configurable number of cycles, then performs the access against internal
// RAM, an LED register or the synchronized switches and pulses mem_ready.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned RAM_WORDS   = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       write_data,
    input  logic [7:0]        SW,
    output logic [15:0]       read_data,
    output logic              mem_ready,
    output logic [7:0]        LEDR,
    output logic              err
);

    localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    // Sequencer state and captured access.
    state_e              state_q;
    logic [3:0]          cnt_q;
    mem_cmd_e            cmd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         wdata_q;

    // Registered outputs.
    logic [15:0]         read_data_q;
    logic                mem_ready_q;
    logic [7:0]          ledr_q;
    logic                err_q;

    // Switch synchronizer.
    logic [7:0]          sw_meta_q;
    logic [7:0]          sw_sync_q;

    // Access execution decode.
    region_e             region_s;
    logic                exec_s;
    logic                ram_we_s;
    logic                access_err_s;
    logic [15:0]         read_data_d;
    logic [7:0]          ledr_d;
    logic [15:0]         ram_rdata_s;

    mem_ram #(
        .WORDS (RAM_WORDS),
        .AW    (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_s),
        .addr_i  (RAM_AW'(addr_q)),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata_s)
    );

    // Decode the captured access into RAM strobe, next outputs and error.
    always_comb begin
        region_s     = decode_addr(32'(addr_q), 32'(RAM_WORDS));
        exec_s       = (state_q == ST_BUSY) && (cnt_q == 4'd0);
        ram_we_s     = 1'b0;
        access_err_s = 1'b0;
        read_data_d  = read_data_q;
        ledr_d       = ledr_q;
        case (region_s)
            RGN_RAM: begin
                if (cmd_q == MWRITE) begin
                    ram_we_s = exec_s;
                end else begin
                    read_data_d = ram_rdata_s;
                end
            end
            RGN_LED: begin
                if (cmd_q == MWRITE) begin
                    ledr_d = wdata_q[7:0];
                end else begin
                    access_err_s = 1'b1;
                end
            end
            RGN_SW: begin
                if (cmd_q == MREAD) begin
                    read_data_d = {8'h00, sw_sync_q};
                end else begin
                    access_err_s = 1'b1;
                end
            end
            default: begin
                access_err_s = 1'b1;
                if (cmd_q == MREAD) begin
                    read_data_d = 16'h0000;
                end else begin
                    read_data_d = read_data_q;
                end
            end
        endcase
    end

    // Two-flop synchronizer for the asynchronous switch inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_q <= 8'h00;
            sw_sync_q <= 8'h00;
        end else begin
            sw_meta_q <= SW;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Access sequencer: IDLE accepts, BUSY counts down then executes, DONE
    // swallows one cycle so a held command is not taken twice.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            cmd_q       <= MNONE;
            addr_q      <= '0;
            wdata_q     <= 16'h0000;
            read_data_q <= 16'h0000;
            mem_ready_q <= 1'b0;
            ledr_q      <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            mem_ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    case (mem_cmd_e'(mem_cmd))
                        MREAD, MWRITE: begin
                            cmd_q   <= mem_cmd_e'(mem_cmd);
                            addr_q  <= mem_addr;
                            wdata_q <= write_data;
                            cnt_q   <= 4'(WAIT_CYCLES);
                            state_q <= ST_BUSY;
                        end
                        MILLEGAL: begin
                            err_q <= 1'b1;
                        end
                        default: begin
                            state_q <= ST_IDLE;
                        end
                    endcase
                end
                ST_BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        read_data_q <= read_data_d;
                        ledr_q      <= ledr_d;
                        err_q       <= err_q | access_err_s;
                        mem_ready_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    assign read_data = read_data_q;
    assign mem_ready = mem_ready_q;
    assign LEDR      = ledr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a behavioural memory-map model predicts
// each completion, a monitor pops and compares whenever mem_ready pulses.
module tb_mem_responder;

    localparam int unsigned W = 1;
    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_RD   = 2'b01;
    localparam logic [1:0] C_WR   = 2'b10;
    localparam logic [1:0] C_BAD  = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  mem_cmd = 2'b00;
    logic [8:0]  mem_addr = 9'h000;
    logic [15:0] write_data = 16'h0000;
    logic [7:0]  SW = 8'h00;
    logic [15:0] read_data;
    logic        mem_ready;
    logic [7:0]  LEDR;
    logic        err;

    // second instance with zero wait cycles
    logic [1:0]  c0_cmd = 2'b00;
    logic [8:0]  c0_addr = 9'h000;
    logic [15:0] c0_wdata = 16'h0000;
    logic [15:0] c0_rdata;
    logic        c0_ready;
    logic [7:0]  c0_led;
    logic        c0_err;

    mem_responder #(.WAIT_CYCLES(W), .ADDR_W(9), .RAM_WORDS(256)) u_dut (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .SW(SW), .read_data(read_data),
        .mem_ready(mem_ready), .LEDR(LEDR), .err(err)
    );

    mem_responder #(.WAIT_CYCLES(0), .ADDR_W(9), .RAM_WORDS(256)) u_dut0 (
        .clk(clk), .reset(reset), .mem_cmd(c0_cmd), .mem_addr(c0_addr),
        .write_data(c0_wdata), .SW(SW), .read_data(c0_rdata),
        .mem_ready(c0_ready), .LEDR(c0_led), .err(c0_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] rd;
        logic [7:0]  led;
        logic        er;
        int unsigned at;
    } exp_t;
    exp_t sb_q[$];

    // reference model state
    logic [15:0] ram_m [0:255];
    logic [15:0] rd_m  = 16'h0000;
    logic [7:0]  led_m = 8'h00;
    logic        err_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // memory map semantics applied to the model
    task automatic model(input logic [1:0] cmd, input logic [8:0] a, input logic [15:0] d);
        if (a == 9'h100) begin
            if (cmd == C_WR) led_m = d[7:0];
            else err_m = 1'b1;
        end else if (a == 9'h140) begin
            if (cmd == C_RD) rd_m = {8'h00, SW};
            else err_m = 1'b1;
        end else if (a < 9'd256) begin
            if (cmd == C_WR) ram_m[a[7:0]] = d;
            else rd_m = ram_m[a[7:0]];
        end else begin
            err_m = 1'b1;
            if (cmd == C_RD) rd_m = 16'h0000;
        end
    endtask

    // issue one access, predict its completion, wait (bounded) for ready
    task automatic access(input logic [1:0] cmd, input logic [8:0] a, input logic [15:0] d);
        exp_t e;
        bit seen;
        @(negedge clk);
        mem_cmd = cmd; mem_addr = a; write_data = d;
        model(cmd, a, d);
        e.rd = rd_m; e.led = led_m; e.er = err_m; e.at = cyc + W + 2;
        sb_q.push_back(e);
        @(posedge clk);
        #1 mem_cmd = C_NONE;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_ready) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++; n_err++;
            $display("FAIL ready_timeout: got no mem_ready expected one for addr %h", a);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_read_data"}, 32'(read_data), 32'h0000);
        check({tag, "_ready"},     32'(mem_ready), 32'h0);
        check({tag, "_ledr"},      32'(LEDR),      32'h00);
        check({tag, "_err"},       32'(err),       32'h0);
    endtask

    // monitor: every completion pulse must match the next prediction
    exp_t got_e;
    always @(negedge clk) begin
        if (reset && mem_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL unexpected_ready: got mem_ready expected none (cycle %0d)", cyc);
            end else begin
                got_e = sb_q.pop_front();
                check("latency",   32'(cyc),       32'(got_e.at));
                check("read_data", 32'(read_data), 32'(got_e.rd));
                check("ledr",      32'(LEDR),      32'(got_e.led));
                check("err",       32'(err),       32'(got_e.er));
            end
        end
    end

    logic [15:0] rnd_d;
    logic [8:0]  rnd_a;
    logic [1:0]  rnd_c;
    logic [11:0] pat;
    logic [11:0] exp_pat;
    logic [8:0]  unmapped [0:3];

    initial begin
        unmapped[0] = 9'h1FF; unmapped[1] = 9'h101;
        unmapped[2] = 9'h150; unmapped[3] = 9'h13F;

        // reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        // fill the low RAM so later reads have known contents
        for (int i = 0; i < 32; i++) begin
            rnd_d = 16'($urandom);
            access(C_WR, 9'(i), rnd_d);
        end

        // write then read back
        access(C_WR, 9'h005, 16'hABCD);
        access(C_RD, 9'h005, 16'h0000);
        check("rd_abcd", 32'(read_data), 32'hABCD);

        // LED write leaves read_data alone
        access(C_WR, 9'h100, 16'h12A5);
        check("led_a5", 32'(LEDR), 32'hA5);
        check("led_rd_hold", 32'(read_data), 32'hABCD);
        check("led_err0", 32'(err), 32'h0);

        // synchronized switches
        SW = 8'h3C;
        repeat (3) @(negedge clk);
        access(C_RD, 9'h140, 16'h0000);
        check("sw_3c", 32'(read_data), 32'h003C);

        // unmapped read sets sticky err
        access(C_RD, 9'h1FF, 16'h0000);
        check("unmapped_rd", 32'(read_data), 32'h0000);
        repeat (10) @(negedge clk);
        check("err_sticky", 32'(err), 32'h1);

        // reset during BUSY aborts the write
        @(negedge clk);
        mem_cmd = C_WR; mem_addr = 9'h010; write_data = 16'h7777;
        @(posedge clk);
        #1 mem_cmd = C_NONE;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        rd_m = 16'h0000; led_m = 8'h00; err_m = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("abort_hold");
        reset = 1'b1;
        access(C_RD, 9'h010, 16'h0000);
        check("abort_no_write", 32'(read_data), 32'(ram_m[8'h10]));

        // illegal command: err without any completion
        @(negedge clk);
        mem_cmd = C_BAD;
        @(posedge clk);
        #1 mem_cmd = C_NONE;
        err_m = 1'b1;
        repeat (3) @(negedge clk);
        check("illegal_err", 32'(err), 32'h1);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: begin
                    rnd_a = 9'($urandom_range(0, 31));
                    rnd_c = ($urandom_range(0, 1) == 0) ? C_RD : C_WR;
                    rnd_d = 16'($urandom);
                    access(rnd_c, rnd_a, rnd_d);
                end
                6: begin
                    rnd_c = ($urandom_range(0, 1) == 0) ? C_RD : C_WR;
                    rnd_d = 16'($urandom);
                    access(rnd_c, 9'h100, rnd_d);
                end
                7: begin
                    SW = 8'($urandom);
                    repeat (3) @(negedge clk);
                    rnd_c = ($urandom_range(0, 3) == 0) ? C_WR : C_RD;
                    access(rnd_c, 9'h140, 16'($urandom));
                end
                8: begin
                    rnd_a = unmapped[$urandom_range(0, 3)];
                    rnd_c = ($urandom_range(0, 1) == 0) ? C_RD : C_WR;
                    access(rnd_c, rnd_a, 16'($urandom));
                end
                default: begin
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                end
            endcase
        end

        // zero-wait instance with the read held through DONE
        @(negedge clk);
        c0_cmd = C_RD; c0_addr = 9'h140;
        pat = 12'h000;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            pat[k-1] = c0_ready;
            exp_pat[k-1] = ((k % 3) == 2);
        end
        c0_cmd = C_NONE;
        check("held_cmd_pulses", 32'(pat), 32'(exp_pat));
        check("w0_sw_read", 32'(c0_rdata), 32'({8'h00, SW}));

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
